// File: rtl/tree_pkg.sv
// Shared definitions for the tree classifier inter-level pipeline stage.
// Holds default datapath widths and the per-lane skid-buffer state encoding.
package tree_pkg;

    localparam int unsigned DEF_PACKET_WIDTH = 104;
    localparam int unsigned DEF_NODE_WIDTH   = 40;
    localparam int unsigned DEF_LANES        = 2;
    localparam int unsigned DEF_CNT_WIDTH    = 16;

    // EMPTY: nothing held; BUSY: main entry valid; FULL: main and skid valid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } lane_state_e;

endpackage

// File: rtl/tree_lane_skid.sv
// One lane of the tree stage: a 2-entry skid buffer with valid/ready handshake,
// synchronous flush and an accepted-transfer counter.
module tree_lane_skid
    import tree_pkg::*;
#(
    parameter int unsigned PACKET_WIDTH = DEF_PACKET_WIDTH,
    parameter int unsigned NODE_WIDTH   = DEF_NODE_WIDTH,
    parameter int unsigned CNT_WIDTH    = DEF_CNT_WIDTH
) (
    input  logic                    clk,
    input  logic                    RSTn,
    input  logic                    flush_i,
    input  logic                    cnt_clr_i,
    input  logic [PACKET_WIDTH-1:0] packet_i,
    input  logic [NODE_WIDTH-1:0]   node_i,
    input  logic                    matched_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [PACKET_WIDTH-1:0] packet_o,
    output logic [NODE_WIDTH-1:0]   node_o,
    output logic                    matched_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [CNT_WIDTH-1:0]    acc_cnt_o
);

    localparam int unsigned DW = PACKET_WIDTH + NODE_WIDTH + 1;

    lane_state_e          state_q, state_d;
    logic [DW-1:0]        main_q, main_d;
    logic [DW-1:0]        skid_q, skid_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic [DW-1:0] in_word;
    logic          accept;
    logic          emit;
    logic          accept_cnt;

    assign in_word = {packet_i, node_i, matched_i};

    // Handshake outputs come straight from the state register.
    assign ready_o = (state_q != ST_FULL);
    assign valid_o = (state_q != ST_EMPTY);

    assign accept     = valid_i && ready_o;
    assign emit       = valid_o && ready_i;
    assign accept_cnt = accept && !flush_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_d  = in_word;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (accept && emit) begin
                    main_d = in_word;
                end else if (accept) begin
                    skid_d  = in_word;
                    state_d = ST_FULL;
                end else if (emit) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (emit) begin
                    main_d  = skid_q;
                    state_d = ST_BUSY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // Flush wins over everything; data registers keep their contents.
        if (flush_i) begin
            state_d = ST_EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    always_comb begin
        if (cnt_clr_i) begin
            cnt_d = CNT_WIDTH'(accept_cnt);
        end else begin
            cnt_d = cnt_q + CNT_WIDTH'(accept_cnt);
        end
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign {packet_o, node_o, matched_o} = main_q;
    assign acc_cnt_o = cnt_q;

endmodule

// File: rtl/tree_stage_skid_reg.sv
// Inter-level pipeline stage of the tree classifier: LANES independent skid
// lanes carrying {packet header, node word, matched flag} from level k to k+1.
module tree_stage_skid_reg
    import tree_pkg::*;
#(
    parameter int unsigned PACKET_WIDTH = DEF_PACKET_WIDTH,
    parameter int unsigned NODE_WIDTH   = DEF_NODE_WIDTH,
    parameter int unsigned LANES        = DEF_LANES,
    parameter int unsigned CNT_WIDTH    = DEF_CNT_WIDTH
) (
    input  logic                          clk,
    input  logic                          RSTn,
    input  logic                          flush,
    input  logic                          cnt_clr,
    input  logic [LANES*PACKET_WIDTH-1:0] packet_in,
    input  logic [LANES*NODE_WIDTH-1:0]   node_in,
    input  logic [LANES-1:0]              matched_in,
    input  logic [LANES-1:0]              valid_in,
    output logic [LANES-1:0]              ready_out,
    output logic [LANES*PACKET_WIDTH-1:0] packet_out,
    output logic [LANES*NODE_WIDTH-1:0]   node_out,
    output logic [LANES-1:0]              matched_out,
    output logic [LANES-1:0]              valid_out,
    input  logic [LANES-1:0]              ready_in,
    output logic [LANES*CNT_WIDTH-1:0]    acc_cnt
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        tree_lane_skid #(
            .PACKET_WIDTH (PACKET_WIDTH),
            .NODE_WIDTH   (NODE_WIDTH),
            .CNT_WIDTH    (CNT_WIDTH)
        ) u_lane (
            .clk       (clk),
            .RSTn      (RSTn),
            .flush_i   (flush),
            .cnt_clr_i (cnt_clr),
            .packet_i  (packet_in[i*PACKET_WIDTH +: PACKET_WIDTH]),
            .node_i    (node_in[i*NODE_WIDTH +: NODE_WIDTH]),
            .matched_i (matched_in[i]),
            .valid_i   (valid_in[i]),
            .ready_o   (ready_out[i]),
            .packet_o  (packet_out[i*PACKET_WIDTH +: PACKET_WIDTH]),
            .node_o    (node_out[i*NODE_WIDTH +: NODE_WIDTH]),
            .matched_o (matched_out[i]),
            .valid_o   (valid_out[i]),
            .ready_i   (ready_in[i]),
            .acc_cnt_o (acc_cnt[i*CNT_WIDTH +: CNT_WIDTH])
        );
    end

endmodule
